core_bus_sram_responder: RTL
============================

Name: core_bus_sram_responder

Overview:
- Responder (slave) end of the core's simple memory bus: rd_en/wr_en, addr, wr_data, size, rd_data, rd_vld, busy.
- Serves a single-port on-chip SRAM window mapped at BASE_ADDR.
- Supports byte, halfword and word accesses, a configurable wait-state count, and error signalling for bad requests.
- Sits between the processor core's bus port and the SoC data memory.

Parameters:
- ADDR_W, 10: word-address width; the window is 2^ADDR_W 32-bit words (4 KB by default).
- BASE_ADDR, 32'h2000_0000: window base; bits [ADDR_W+1:0] must be zero.
- WAIT_CYCLES, 1: extra busy cycles before each access commits; range 0..15.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous reset, active-high.
- ahb_rd_en  in  1  read request, sampled while ahb_busy=0.
- ahb_wr_en  in  1  write request, sampled while ahb_busy=0.
- ahb_addr  in  32  byte address.
- ahb_wr_data  in  32  write data, right-justified (byte in [7:0], halfword in [15:0]).
- ahb_size  in  2  transfer size: 00 byte, 01 halfword, 10 word, 11 reserved.
- ahb_rd_data  out  32  read data, right-justified, zero-extended.
- ahb_rd_vld  out  1  one-cycle read-response strobe.
- ahb_busy  out  1  responder occupied; new requests are ignored while high.
- ahb_err  out  1  one-cycle error strobe, issued in the response cycle.

Behaviour:
- Reset values: ahb_rd_data=0, ahb_rd_vld=0, ahb_busy=0, ahb_err=0; FSM in IDLE. SRAM contents are not reset.
- FSM states are IDLE, WAIT, ACCESS and RESP.
- Accept: in IDLE or RESP, when ahb_busy=0 and (rd_en|wr_en), the next edge latches addr, wr_data, size and kind.
  - Next state is WAIT if WAIT_CYCLES>0, otherwise ACCESS.
  - Requests seen while ahb_busy=1 are ignored and not queued.
- WAIT: a 4-bit counter loaded with WAIT_CYCLES-1 on accept decrements each cycle; at 0 the FSM goes to ACCESS. ahb_busy=1.
- ACCESS: one cycle, ahb_busy=1.
  - Writes: byte-enable merge commits to the SRAM at the end of this cycle.
  - Reads: the SRAM word is registered.
  - Next state is RESP.
- RESP: one cycle, ahb_busy=0.
  - Reads: ahb_rd_vld=1 and ahb_rd_data is updated in this cycle.
  - Writes: ahb_rd_vld stays 0.
  - Any error: ahb_err=1.
  - Next state is IDLE, or WAIT/ACCESS if a new request is accepted in this cycle (back-to-back).
- Latency: with the request in cycle C0, ahb_busy is high in C1..C(WAIT_CYCLES+1) and RESP falls in C(WAIT_CYCLES+2). Default: response 3 cycles after the request.
- ahb_rd_data holds its value until the next read response.
- Byte lanes are little-endian, with lane = addr[1:0].
  - Byte write: wr_data[7:0] goes to lane addr[1:0].
  - Halfword write: wr_data[15:0] goes to lanes {addr[1],0}+1 : {addr[1],0}.
  - Reads extract the same lanes and zero-extend them. Sign extension belongs to the core.
- Error conditions are checked at accept:
  - addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2];
  - halfword with addr[0]=1;
  - word with addr[1:0]!=0;
  - size=11;
  - rd_en and wr_en both high.
- An errored transaction still runs the full WAIT/ACCESS/RESP timing, but:
  - it leaves the SRAM unmodified;
  - an errored read returns ahb_rd_data=0 with ahb_rd_vld=1;
  - the rd_en+wr_en case responds like a read (rd_vld=1, data 0).
- Reset mid-transaction: everything returns to reset values immediately; a pending write is discarded (no partial commit).
- SRAM index is addr[ADDR_W+1:2]. There is no wrap-around outside the window, because out-of-window accesses are errors.

Test Plan:
- Word write 0xDEADBEEF to 0x2000_0010, then word read -> ahb_busy high for 2 cycles, rd_vld in cycle C3 with 0xDEADBEEF, err=0.
- Byte write 0x11 to 0x2000_0011 -> word read of 0x2000_0010 = 0xDEAD11EF; halfword read at 0x2000_0012 = 0x0000DEAD; byte read at 0x2000_0013 = 0x0000_00DE.
- Misaligned halfword read at 0x2000_0011 and size=11 write -> err pulse in RESP; read returns rd_vld=1 with data 0; subsequent word read still 0xDEAD11EF.
- Write 0x1234_5678 to 0x3000_0000 (out of window) -> err=1 in RESP, no rd_vld; word at 0x2000_0000 unchanged.
- Back-to-back read issued in the RESP cycle of a prior write -> accepted with no idle gap; rd_vld 3 cycles later. A request pulsed while busy=1 produces no response.
- Assert rst during WAIT of a write of 0xCAFEF00D to 0x2000_0020 -> all outputs 0 during reset; afterwards a read of 0x2000_0020 returns the prior contents. Repeat with WAIT_CYCLES=0: response 2 cycles after the request.

Source files
------------

// File: rtl/core_bus_sram_responder.sv
// rtl/core_bus_sram_responder.sv - single-port SRAM responder for the core memory bus
module core_bus_sram_responder #(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'h2000_0000,
  parameter int          WAIT_CYCLES = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        ahb_rd_en,
  input  logic        ahb_wr_en,
  input  logic [31:0] ahb_addr,
  input  logic [31:0] ahb_wr_data,
  input  logic [1:0]  ahb_size,
  output logic [31:0] ahb_rd_data,
  output logic        ahb_rd_vld,
  output logic        ahb_busy,
  output logic        ahb_err
);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACCESS, S_RESP} state_t;

  localparam logic [3:0] WAIT_LOAD = (WAIT_CYCLES > 0) ? 4'(WAIT_CYCLES - 1) : 4'd0;

  state_t            state_q, state_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic [1:0]        off_q, off_d;
  logic [1:0]        size_q, size_d;
  logic [31:0]       wdata_q, wdata_d;
  logic [31:0]       rd_data_q, rd_data_d;
  logic              is_rd_q, is_rd_d;
  logic              is_wr_q, is_wr_d;
  logic              err_q, err_d;

  logic [31:0] sram [2**ADDR_W];

  logic        req_err;
  logic        sram_we;
  logic [31:0] sram_word, lane_word, rd_extract, wr_lanes;
  logic [3:0]  wr_be;

  // Request validity: window, alignment, size encoding and conflicting kind
  always_comb begin
    req_err = 1'b0;
    if (ahb_addr[31:ADDR_W+2] != BASE_ADDR[31:ADDR_W+2]) req_err = 1'b1;
    case (ahb_size)
      2'b00:   ;
      2'b01:   if (ahb_addr[0]) req_err = 1'b1;
      2'b10:   if (ahb_addr[1:0] != 2'b00) req_err = 1'b1;
      default: req_err = 1'b1;
    endcase
    if (ahb_rd_en && ahb_wr_en) req_err = 1'b1;
  end

  // Little-endian lane steering for read extraction and write byte enables
  always_comb begin
    sram_word = sram[idx_q];
    lane_word = sram_word >> {off_q, 3'b000};
    case (size_q)
      2'b00: begin
        rd_extract = {24'd0, lane_word[7:0]};
        wr_be      = 4'b0001 << off_q;
        wr_lanes   = {4{wdata_q[7:0]}};
      end
      2'b01: begin
        rd_extract = {16'd0, lane_word[15:0]};
        wr_be      = off_q[1] ? 4'b1100 : 4'b0011;
        wr_lanes   = {2{wdata_q[15:0]}};
      end
      default: begin
        rd_extract = lane_word;
        wr_be      = 4'b1111;
        wr_lanes   = wdata_q;
      end
    endcase
  end

  // Errored transactions keep their timing but never touch the array
  assign sram_we = (state_q == S_ACCESS) && is_wr_q && !err_q;

  // Next-state: accept in IDLE/RESP, count wait states, access, respond
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    off_d     = off_q;
    size_d    = size_q;
    wdata_d   = wdata_q;
    rd_data_d = rd_data_q;
    is_rd_d   = is_rd_q;
    is_wr_d   = is_wr_q;
    err_d     = err_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        state_d = S_IDLE;
        if (ahb_rd_en || ahb_wr_en) begin
          idx_d   = ahb_addr[ADDR_W+1:2];
          off_d   = ahb_addr[1:0];
          size_d  = ahb_size;
          wdata_d = ahb_wr_data;
          is_rd_d = ahb_rd_en;
          is_wr_d = ahb_wr_en && !ahb_rd_en;
          err_d   = req_err;
          cnt_d   = WAIT_LOAD;
          state_d = (WAIT_CYCLES > 0) ? S_WAIT : S_ACCESS;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: begin
        state_d = S_RESP;
        if (is_rd_q) rd_data_d = err_q ? 32'd0 : rd_extract;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Control and response registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      idx_q     <= '0;
      off_q     <= 2'd0;
      size_q    <= 2'd0;
      wdata_q   <= 32'd0;
      rd_data_q <= 32'd0;
      is_rd_q   <= 1'b0;
      is_wr_q   <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      off_q     <= off_d;
      size_q    <= size_d;
      wdata_q   <= wdata_d;
      rd_data_q <= rd_data_d;
      is_rd_q   <= is_rd_d;
      is_wr_q   <= is_wr_d;
      err_q     <= err_d;
    end
  end

  // SRAM byte-masked write port; contents are deliberately not reset
  always_ff @(posedge clk) begin
    if (sram_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wr_be[i]) sram[idx_q][8*i +: 8] <= wr_lanes[8*i +: 8];
      end
    end
  end

  assign ahb_busy    = (state_q == S_WAIT) || (state_q == S_ACCESS);
  assign ahb_rd_vld  = (state_q == S_RESP) && is_rd_q;
  assign ahb_err     = (state_q == S_RESP) && err_q;
  assign ahb_rd_data = rd_data_q;

endmodule
